// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side fetch/load-store ports and the unified memory req/ack port,
// grouped for the shared-memory arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_kill;
    logic [DW-1:0] if_rdata;
    logic          if_ready;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;

    logic          pipe_stall;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, if_kill, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready, pipe_stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    // Pipeline and memory side.
    modport master (
        output if_req, if_addr, if_kill, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready, pipe_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and load/store accesses onto one single-port memory
// and stalls the pipeline until every access wanted this cycle has completed.
//
//   state   | meaning
//   IDLE    | no memory transaction outstanding; arbitrate (DM over IF)
//   BUSY_IF | fetch transaction issued, waiting for mem_ack
//   BUSY_DM | load/store transaction issued, waiting for mem_ack
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_if_data;
    logic [DW-1:0] r_dm_data;
    logic          r_if_done;
    logic          r_dm_done;
    logic          r_drop;

    logic w_if_pend;
    logic w_dm_pend;
    logic w_grant_if;
    logic w_grant_dm;
    logic w_if_ack;
    logic w_dm_ack;
    logic w_if_ready;
    logic w_stall;

    assign w_if_pend  = bus.if_req & ~r_if_done & ~bus.if_kill;
    assign w_dm_pend  = bus.dm_req & ~r_dm_done;
    assign w_if_ack   = (r_state == BUSY_IF) & bus.mem_ack;
    assign w_dm_ack   = (r_state == BUSY_DM) & bus.mem_ack;
    // A fetch killed while in flight still completes on the bus but is never reported.
    assign w_if_ready = w_if_ack & ~r_drop;
    assign w_stall    = (bus.if_req & ~bus.if_kill & ~(r_if_done | w_if_ready))
                      | (bus.dm_req & ~(r_dm_done | w_dm_ack));

    assign bus.if_ready   = w_if_ready;
    assign bus.dm_ready   = w_dm_ack;
    assign bus.if_rdata   = w_if_ready ? bus.mem_rdata : r_if_data;
    assign bus.dm_rdata   = w_dm_ack   ? bus.mem_rdata : r_dm_data;
    assign bus.pipe_stall = w_stall;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_dm  = 1'b0;
        case (r_state)
            IDLE: begin
                // The MEM-stage access belongs to the older instruction, so it goes first.
                if (w_dm_pend) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = BUSY_DM;
                end else if (w_if_pend) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (bus.mem_ack) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_data   <= '0;
            r_dm_data   <= '0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant_dm) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= bus.dm_we;
                r_mem_addr  <= bus.dm_addr;
                r_mem_wdata <= bus.dm_wdata;
            end else if (w_grant_if) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= bus.if_addr;
                r_mem_wdata <= '0;
            end else if (w_if_ack || w_dm_ack) begin
                r_mem_req   <= 1'b0;
            end

            if (w_if_ready) r_if_data <= bus.mem_rdata;
            if (w_dm_ack)   r_dm_data <= bus.mem_rdata;

            // Pipeline advancing consumes both results; otherwise completed work is remembered.
            if (!w_stall) begin
                r_if_done <= 1'b0;
                r_dm_done <= 1'b0;
            end else begin
                if (bus.if_kill)     r_if_done <= 1'b0;
                else if (w_if_ready) r_if_done <= 1'b1;
                if (w_dm_ack)        r_dm_done <= 1'b1;
            end

            if (w_if_ack)                                r_drop <= 1'b0;
            else if (bus.if_kill && r_state == BUSY_IF)  r_drop <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table, kill/reset sequences, and random
// pipeline steps checked against a transaction-level memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
    mem_port_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic ir, input logic [31:0] ia, input logic ik, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                       input logic ack, input logic [31:0] rd);
        bus.if_req = ir; bus.if_addr = ia; bus.if_kill = ik;
        bus.dm_req = dr; bus.dm_we = dw; bus.dm_addr = da; bus.dm_wdata = dwd;
        bus.mem_ack = ack; bus.mem_rdata = rd;
    endtask

    typedef struct {
        logic if_req; logic [31:0] if_addr;
        logic dm_req; logic dm_we; logic [31:0] dm_addr; logic [31:0] dm_wdata;
        logic mem_ack; logic [31:0] mem_rdata;
        logic e_req; logic [31:0] e_addr; logic e_we; logic [31:0] e_wdata;
        logic e_ifr; logic e_dmr; logic e_stall;
        logic c_ifd; logic [31:0] e_ifd; logic c_dmd; logic [31:0] e_dmd;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    vec_t tbl[$];

    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] dev_mem   [logic [31:0]];
    txn_t exp_q[$];
    txn_t got_q[$];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    logic        ireq, dreq, dwe, txn_open, done;
    logic [31:0] ia, da, dwd, e_ifd, e_dmd, got_ifd, got_dmd, t_addr;
    int          lat, n_ifr, n_dmr, cyc, nchk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset mem_req",   bus.mem_req,   0);
        chk("reset mem_we",    bus.mem_we,    0);
        chk("reset mem_addr",  bus.mem_addr,  0);
        chk("reset mem_wdata", bus.mem_wdata, 0);
        chk("reset if_ready",  bus.if_ready,  0);
        chk("reset dm_ready",  bus.dm_ready,  0);
        chk("reset stall",     bus.pipe_stall, 0);
        chk("reset if_rdata",  bus.if_rdata,  0);
        chk("reset dm_rdata",  bus.dm_rdata,  0);
        @(negedge clk);

        // if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ack, rdata |
        // e_req, e_addr, e_we, e_wdata, e_ifr, e_dmr, e_stall, c_ifd, e_ifd, c_dmd, e_dmd
        // IF-only fetch, ack two cycles after the request
        tbl.push_back('{1, 32'h100, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h100, 0, 0, 0, 0, 0, 0,           1, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h100, 0, 0, 0, 0, 1, 32'h13,      1, 32'h100, 0, 0, 1, 0, 0, 1, 32'h13, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 1, 32'h13, 0, 0});
        // load and fetch together: DM first, stall until both done
        tbl.push_back('{1, 32'h104, 1, 0, 32'h2000, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h104, 1, 0, 32'h2000, 0, 1, 32'hAAAA0001,
                        1, 32'h2000, 0, 0, 0, 1, 1, 0, 0, 1, 32'hAAAA0001});
        tbl.push_back('{1, 32'h104, 1, 0, 32'h2000, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hAAAA0001});
        tbl.push_back('{1, 32'h104, 1, 0, 32'h2000, 0, 1, 32'h00500093,
                        1, 32'h104, 0, 0, 1, 0, 0, 1, 32'h00500093, 1, 32'hAAAA0001});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093, 1, 32'hAAAA0001});
        // store
        tbl.push_back('{0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 0, 0, 1, 32'h2004, 1, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 1, 0, 1, 32'h2004, 1, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // spurious ack in IDLE, then a normal fetch proves state stayed IDLE
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h77,            0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093, 0, 0});
        tbl.push_back('{1, 32'h300, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h300, 0, 0, 0, 0, 1, 32'h11,      1, 32'h300, 0, 0, 1, 0, 0, 1, 32'h11, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].if_req, tbl[i].if_addr, 0, tbl[i].dm_req, tbl[i].dm_we, tbl[i].dm_addr,
                tbl[i].dm_wdata, tbl[i].mem_ack, tbl[i].mem_rdata);
            #1;
            chk($sformatf("v%0d mem_req", i), bus.mem_req, tbl[i].e_req);
            if (tbl[i].e_req) begin
                chk($sformatf("v%0d mem_addr", i), bus.mem_addr, tbl[i].e_addr);
                chk($sformatf("v%0d mem_we", i), bus.mem_we, tbl[i].e_we);
                if (tbl[i].e_we) chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, tbl[i].e_wdata);
            end
            chk($sformatf("v%0d if_ready", i), bus.if_ready, tbl[i].e_ifr);
            chk($sformatf("v%0d dm_ready", i), bus.dm_ready, tbl[i].e_dmr);
            chk($sformatf("v%0d stall", i), bus.pipe_stall, tbl[i].e_stall);
            if (tbl[i].c_ifd) chk($sformatf("v%0d if_rdata", i), bus.if_rdata, tbl[i].e_ifd);
            if (tbl[i].c_dmd) chk($sformatf("v%0d dm_rdata", i), bus.dm_rdata, tbl[i].e_dmd);
            @(negedge clk);
        end

        // kill while a fetch is in flight
        drv(1, 32'h180, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("k0 stall", bus.pipe_stall, 1);
        @(negedge clk);
        drv(1, 32'h200, 1, 0, 0, 0, 0, 0, 0); #1;
        chk("k1 mem_req", bus.mem_req, 1);
        chk("k1 mem_addr", bus.mem_addr, 32'h180);
        chk("k1 stall", bus.pipe_stall, 0);
        @(negedge clk);
        drv(1, 32'h200, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("k2 mem_addr", bus.mem_addr, 32'h180);
        chk("k2 stall", bus.pipe_stall, 1);
        @(negedge clk);
        drv(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'hBAD); #1;
        chk("k3 if_ready", bus.if_ready, 0);
        chk("k3 stall", bus.pipe_stall, 1);
        @(negedge clk);
        drv(1, 32'h200, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("k4 mem_req", bus.mem_req, 0);
        chk("k4 stall", bus.pipe_stall, 1);
        @(negedge clk);
        drv(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h600); #1;
        chk("k5 mem_req", bus.mem_req, 1);
        chk("k5 mem_addr", bus.mem_addr, 32'h200);
        chk("k5 if_ready", bus.if_ready, 1);
        chk("k5 if_rdata", bus.if_rdata, 32'h600);
        chk("k5 stall", bus.pipe_stall, 0);
        @(negedge clk);

        // reset during a data access
        drv(0, 0, 0, 1, 0, 32'h2008, 0, 0, 0); #1;
        chk("r0 stall", bus.pipe_stall, 1);
        @(negedge clk);
        rst = 1'b1; #1;
        chk("r1 mem_req", bus.mem_req, 1);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("r2 mem_req", bus.mem_req, 0);
        chk("r2 dm_ready", bus.dm_ready, 0);
        chk("r2 stall", bus.pipe_stall, 1);
        @(negedge clk);
        drv(0, 0, 0, 1, 0, 32'h2008, 0, 1, 32'hCAFE); #1;
        chk("r3 mem_req", bus.mem_req, 1);
        chk("r3 mem_addr", bus.mem_addr, 32'h2008);
        chk("r3 dm_ready", bus.dm_ready, 1);
        chk("r3 dm_rdata", bus.dm_rdata, 32'hCAFE);
        chk("r3 stall", bus.pipe_stall, 0);
        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // random pipeline steps: each step holds its requests until the stall releases
        for (int s = 0; s < 300; s++) begin
            ireq = ($urandom_range(0, 3) != 0);
            dreq = $urandom_range(0, 1);
            dwe  = $urandom_range(0, 1);
            ia   = 32'h1000 + 4 * $urandom_range(0, 15);
            da   = 32'h1000 + 4 * $urandom_range(0, 15);
            dwd  = $urandom;
            exp_q.delete();
            got_q.delete();
            e_dmd = 0;
            e_ifd = 0;
            if (dreq) begin
                exp_q.push_back('{addr: da, we: dwe, wdata: dwe ? dwd : 32'h0});
                if (dwe) model_mem[da] = dwd;
                else     e_dmd = model_rd(da);
            end
            if (ireq) begin
                exp_q.push_back('{addr: ia, we: 1'b0, wdata: 32'h0});
                e_ifd = model_rd(ia);
            end
            drv(ireq, ia, 0, dreq, dwe, da, dwd, 0, 0);
            n_ifr = 0; n_dmr = 0; done = 0; cyc = 0; txn_open = 0; lat = 0;
            got_ifd = 0; got_dmd = 0;
            while (!done && cyc < 40) begin
                bus.mem_ack = 1'b0;
                if (bus.mem_req) begin
                    if (!txn_open) begin
                        txn_open = 1;
                        lat = $urandom_range(0, 2);
                        t_addr = bus.mem_addr;
                    end
                    if (lat == 0) begin
                        chk("rand mem_addr stable", bus.mem_addr, t_addr);
                        bus.mem_ack = 1'b1;
                        got_q.push_back('{addr: bus.mem_addr, we: bus.mem_we,
                                          wdata: bus.mem_we ? bus.mem_wdata : 32'h0});
                        if (bus.mem_we) begin
                            dev_mem[bus.mem_addr] = bus.mem_wdata;
                            bus.mem_rdata = $urandom;
                        end else begin
                            bus.mem_rdata = dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr]
                                                                         : init_val(bus.mem_addr);
                        end
                        txn_open = 0;
                    end else begin
                        lat--;
                    end
                end
                #1;
                if (bus.if_ready) begin n_ifr++; got_ifd = bus.if_rdata; end
                if (bus.dm_ready) begin n_dmr++; got_dmd = bus.dm_rdata; end
                if (!bus.pipe_stall) done = 1;
                @(negedge clk);
                cyc++;
            end
            bus.mem_ack = 1'b0;
            chk($sformatf("s%0d stall released", s), done, 1);
            chk($sformatf("s%0d txn count", s), got_q.size(), exp_q.size());
            nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
            for (int k = 0; k < nchk; k++) begin
                chk($sformatf("s%0d txn%0d addr", s, k), got_q[k].addr, exp_q[k].addr);
                chk($sformatf("s%0d txn%0d we", s, k), got_q[k].we, exp_q[k].we);
                chk($sformatf("s%0d txn%0d wdata", s, k), got_q[k].wdata, exp_q[k].wdata);
            end
            chk($sformatf("s%0d if_ready pulses", s), n_ifr, ireq);
            chk($sformatf("s%0d dm_ready pulses", s), n_dmr, dreq);
            if (ireq)         chk($sformatf("s%0d if_rdata", s), got_ifd, e_ifd);
            if (dreq && !dwe) chk($sformatf("s%0d dm_rdata", s), got_dmd, e_dmd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
